uart_alu_ctrl: RTL and testbench

Sequencer between the UART receiver, the ALU and the UART transmitter in the TP2 design.
- Collects three received bytes in order: operand A, operand B, opcode.
- Presents them to the combinational ALU, captures the result, and sends it back through the transmitter with a one-cycle tx_start pulse.
- Holds off new commands until the transmitter reports completion.
- Flags bytes lost during that window.

---
 rtl/uart_alu_ctrl_pkg.sv | 26 ++
 rtl/uart_alu_ctrl.sv | 128 ++++++++++++
 tb/tb_uart_alu_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_alu_ctrl_pkg.sv
// Shared definitions for the UART/ALU sequencer slice: default widths,
// controller state encodings and a small state-decode helper.
package uart_alu_ctrl_pkg;

    localparam int DBIT_DEF     = 8;
    localparam int NB_OP_DEF    = 6;
    localparam int NB_STATE_DEF = 3;

    typedef enum logic [NB_STATE_DEF-1:0] {
        S_WAIT_A  = 3'd0,
        S_WAIT_B  = 3'd1,
        S_WAIT_OP = 3'd2,
        S_EXEC    = 3'd3,
        S_SEND    = 3'd4,
        S_WAIT_TX = 3'd5
    } state_t;

    // True in the states where a command is in flight and new bytes are refused.
    function automatic logic is_busy_state(input state_t s);
        case (s)
            S_EXEC, S_SEND, S_WAIT_TX: is_busy_state = 1'b1;
            default:                   is_busy_state = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_alu_ctrl.sv
// Sequencer between UART rx, the combinational ALU and UART tx.
// Collects operand A, operand B and the opcode, lets the ALU settle for one
// cycle, launches the result on the transmitter and waits for it to finish.
// Bytes that arrive while a command is in flight are dropped and flagged.
module uart_alu_ctrl
    import uart_alu_ctrl_pkg::*;
#(
    parameter int DBIT     = DBIT_DEF,
    parameter int NB_OP    = NB_OP_DEF,
    parameter int NB_STATE = NB_STATE_DEF
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_rx_done,
    input  logic [DBIT-1:0]   i_rx_data,
    input  logic              i_tx_done,
    input  logic [DBIT-1:0]   i_alu_result,
    output logic [DBIT-1:0]   o_alu_a,
    output logic [DBIT-1:0]   o_alu_b,
    output logic [NB_OP-1:0]  o_alu_op,
    output logic              o_tx_start,
    output logic [DBIT-1:0]   o_tx_data,
    output logic              o_busy,
    output logic              o_overrun
);

    logic [NB_STATE-1:0] state_r;
    state_t              state_s;
    state_t              state_next_s;

    logic [DBIT-1:0]     alu_a_r;
    logic [DBIT-1:0]     alu_b_r;
    logic [NB_OP-1:0]    alu_op_r;
    logic [DBIT-1:0]     tx_data_r;
    logic                tx_start_r;
    logic                busy_r;
    logic                overrun_r;

    assign state_s = state_t'(state_r);

    // State register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_r <= NB_STATE'(S_WAIT_A);
        end else begin
            state_r <= NB_STATE'(state_next_s);
        end
    end

    // Next-state decode; tx_done only matters while waiting on the transmitter.
    always_comb begin
        state_next_s = S_WAIT_A;
        case (state_s)
            S_WAIT_A: begin
                if (i_rx_done) state_next_s = S_WAIT_B;
                else           state_next_s = S_WAIT_A;
            end
            S_WAIT_B: begin
                if (i_rx_done) state_next_s = S_WAIT_OP;
                else           state_next_s = S_WAIT_B;
            end
            S_WAIT_OP: begin
                if (i_rx_done) state_next_s = S_EXEC;
                else           state_next_s = S_WAIT_OP;
            end
            S_EXEC:    state_next_s = S_SEND;
            S_SEND:    state_next_s = S_WAIT_TX;
            S_WAIT_TX: begin
                if (i_tx_done) state_next_s = S_WAIT_A;
                else           state_next_s = S_WAIT_TX;
            end
            default:   state_next_s = S_WAIT_A;
        endcase
    end

    // Operand/opcode capture and result latch; ALU inputs hold until the next A byte.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            alu_a_r   <= {DBIT{1'b0}};
            alu_b_r   <= {DBIT{1'b0}};
            alu_op_r  <= {NB_OP{1'b0}};
            tx_data_r <= {DBIT{1'b0}};
        end else begin
            case (state_s)
                S_WAIT_A: begin
                    if (i_rx_done) alu_a_r <= i_rx_data;
                    else           alu_a_r <= alu_a_r;
                end
                S_WAIT_B: begin
                    if (i_rx_done) alu_b_r <= i_rx_data;
                    else           alu_b_r <= alu_b_r;
                end
                S_WAIT_OP: begin
                    if (i_rx_done) alu_op_r <= i_rx_data[NB_OP-1:0];
                    else           alu_op_r <= alu_op_r;
                end
                S_EXEC:    tx_data_r <= i_alu_result;
                default:   tx_data_r <= tx_data_r;
            endcase
        end
    end

    // Status outputs: start pulse, busy aligned with the state, sticky overrun.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            tx_start_r <= 1'b0;
            busy_r     <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            tx_start_r <= (state_s == S_EXEC);
            busy_r     <= is_busy_state(state_next_s);
            if (i_rx_done && is_busy_state(state_s)) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    assign o_alu_a    = alu_a_r;
    assign o_alu_b    = alu_b_r;
    assign o_alu_op   = alu_op_r;
    assign o_tx_data  = tx_data_r;
    assign o_tx_start = tx_start_r;
    assign o_busy     = busy_r;
    assign o_overrun  = overrun_r;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Scoreboard bench for uart_alu_ctrl: stimulus pushes the expected tx byte and
// its expected start cycle; an independent monitor checks every tx_start pulse.
module tb_uart_alu_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_done = 1'b0;
    logic [7:0] alu_result;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;
    exp_t exp_q[$];

    uart_alu_ctrl dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_rx_done    (rx_done),
        .i_rx_data    (rx_data),
        .i_tx_done    (tx_done),
        .i_alu_result (alu_result),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .o_alu_op     (alu_op),
        .o_tx_start   (tx_start),
        .o_tx_data    (tx_data),
        .o_busy       (busy),
        .o_overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU with the TP2 opcode set.
    always_comb begin
        case (alu_op)
            6'h20:   alu_result = alu_a + alu_b;
            6'h22:   alu_result = alu_a - alu_b;
            6'h24:   alu_result = alu_a & alu_b;
            6'h25:   alu_result = alu_a | alu_b;
            6'h26:   alu_result = alu_a ^ alu_b;
            6'h27:   alu_result = ~(alu_a | alu_b);
            default: alu_result = 8'h00;
        endcase
    end

    // Monitor: every cycle with tx_start high must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && tx_start) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected: tx_start high with tx_data=%h, none expected (cycle %0d)", tx_data, cyc);
            end else begin
                e = exp_q.pop_front();
                if (tx_data !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL tx_result: got data %h at cycle %0d, required %h at cycle %0d", tx_data, cyc, e.data, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, expv);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_alu_a"},    32'(alu_a),    32'h0);
        check({tag, "_alu_b"},    32'(alu_b),    32'h0);
        check({tag, "_alu_op"},   32'(alu_op),   32'h0);
        check({tag, "_tx_data"},  32'(tx_data),  32'h0);
        check({tag, "_tx_start"}, 32'(tx_start), 32'h0);
        check({tag, "_busy"},     32'(busy),     32'h0);
        check({tag, "_overrun"},  32'(overrun),  32'h0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
    endtask

    // Opcode byte: the result must start two clocks after this rx_done.
    task automatic send_op(input logic [7:0] b, input logic [7:0] expv);
        exp_t e;
        @(posedge clk); #1;
        rx_data = b;
        rx_done = 1'b1;
        e.data = expv;
        e.cyc  = cyc + 2;
        exp_q.push_back(e);
        @(posedge clk); #1;
        rx_done = 1'b0;
    endtask

    task automatic wait_tx_start();
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_start) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL tx_timeout: tx_start not seen within 20 cycles, required a pulse");
        end
    endtask

    task automatic finish_tx(input logic [7:0] expv);
        repeat (3) @(negedge clk);
        check("busy_in_wait_tx", 32'(busy), 32'h1);
        check("tx_data_stable", 32'(tx_data), 32'(expv));
        @(posedge clk); #1;
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
        @(negedge clk);
        check("busy_after_tx_done", 32'(busy), 32'h0);
    endtask

    task automatic do_cmd(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] op, input logic [7:0] expv);
        send_byte(a);
        send_byte(b);
        send_op(op, expv);
        wait_tx_start();
        finish_tx(expv);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic ADD
        do_cmd(8'h05, 8'h03, 8'h20, 8'h08);

        // OR then SUB back-to-back
        do_cmd(8'hF0, 8'h0F, 8'h25, 8'hFF);
        do_cmd(8'h01, 8'h01, 8'h22, 8'h00);
        check("overrun_clean", 32'(overrun), 32'h0);

        // Extra byte while waiting on the transmitter
        send_byte(8'h11);
        send_byte(8'h22);
        send_op(8'h20, 8'h33);
        wait_tx_start();
        send_byte(8'hAA);
        @(negedge clk);
        check("overrun_set", 32'(overrun), 32'h1);
        check("alu_a_kept", 32'(alu_a), 32'h11);
        finish_tx(8'h33);
        do_cmd(8'h0C, 8'h0A, 8'h26, 8'h06);
        check("alu_a_after_overrun", 32'(alu_a), 32'h0C);
        check("overrun_sticky", 32'(overrun), 32'h1);

        // Asynchronous reset after byte B
        send_byte(8'h33);
        send_byte(8'h44);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("rst_after_b");
        @(posedge clk); #1;
        rst = 1'b0;

        // Asynchronous reset while waiting on the transmitter
        send_byte(8'h09);
        send_byte(8'h04);
        send_op(8'h22, 8'h05);
        wait_tx_start();
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("rst_in_wait_tx");
        @(posedge clk); #1;
        rst = 1'b0;

        // Opcode upper bits discarded: 0xE4 -> 0x24 (AND)
        send_byte(8'h0F);
        send_byte(8'h3C);
        send_op(8'hE4, 8'h0C);
        @(negedge clk);
        check("alu_op_truncated", 32'(alu_op), 32'h24);
        wait_tx_start();
        finish_tx(8'h0C);

        // tx_done together with rx_done in the wait state
        send_byte(8'h02);
        send_byte(8'h03);
        send_op(8'h20, 8'h05);
        wait_tx_start();
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        tx_done = 1'b1;
        rx_done = 1'b1;
        rx_data = 8'h77;
        @(posedge clk); #1;
        tx_done = 1'b0;
        rx_done = 1'b0;
        @(negedge clk);
        check("overrun_on_tx_done", 32'(overrun), 32'h1);
        check("busy_on_tx_done", 32'(busy), 32'h0);
        check("alu_a_not_taken", 32'(alu_a), 32'h02);
        do_cmd(8'h04, 8'h05, 8'h20, 8'h09);
        check("alu_a_next_cmd", 32'(alu_a), 32'h04);
        check("alu_b_next_cmd", 32'(alu_b), 32'h05);

        // tx_done outside the wait state is ignored
        send_byte(8'h07);
        @(posedge clk); #1;
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
        @(negedge clk);
        check("busy_tx_done_in_b", 32'(busy), 32'h0);
        check("alu_a_tx_done_in_b", 32'(alu_a), 32'h07);
        send_byte(8'h02);
        send_op(8'h20, 8'h09);
        wait_tx_start();
        finish_tx(8'h09);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
